// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request in, programmable wait states, byte/half/word
// access on a word-organised SRAM, valid/ready response out. Optional DATA_MEM_STATS_EN adds op counters.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_write_ctrl,
  input  logic [2:0]  req_read_ctrl,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
`ifdef DATA_MEM_STATS_EN
  ,
  output logic [31:0] read_count,
  output logic [31:0] write_count
`endif
);
  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  wctl;
    logic [2:0]  rctl;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         state;
  logic [3:0]     cnt;
  req_t           req_q;
  logic           do_op, is_half, is_word, acc_err;
  logic [3:0]     be;
  logic [3:0][7:0] wlane, rd_word;
  logic [7:0]     rbyte;
  logic [15:0]    rhalf;
  logic [31:0]    rdata_next;
  logic [AW-1:0]  widx;

  assign widx  = req_q.addr[AW+1:2];
  assign do_op = (state == S_WAIT) && (cnt == 4'd0);

  always_comb begin
    is_half = (req_q.wctl == 2'b10) || (req_q.rctl == 3'b010) || (req_q.rctl == 3'b101);
    is_word = (req_q.wctl == 2'b11) || (req_q.rctl == 3'b011);
    // range is only checked for real accesses; a no-op never errors
    acc_err = (is_half && req_q.addr[0]) ||
              (is_word && (req_q.addr[1:0] != 2'b00)) ||
              (((req_q.wctl != 2'b00) || (req_q.rctl != 3'b000)) && ({1'b0, req_q.addr} >= ADDR_LIMIT)) ||
              ((req_q.wctl != 2'b00) && (req_q.rctl != 3'b000)) ||
              (req_q.rctl[2:1] == 2'b11);
  end

  always_comb begin
    be    = 4'b0000;
    wlane = req_q.wdata;
    case (req_q.wctl)
      2'b01: begin be = 4'b0001 << req_q.addr[1:0]; wlane = {4{req_q.wdata[7:0]}};  end
      2'b10: begin be = req_q.addr[1] ? 4'b1100 : 4'b0011; wlane = {2{req_q.wdata[15:0]}}; end
      2'b11: be = 4'b1111;
      default: ;
    endcase
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    always_ff @(posedge clk)
      if (do_op && !acc_err && be[l]) lane_mem[widx] <= wlane[l];
    assign rd_word[l] = lane_mem[widx];
  end

  always_comb begin
    rbyte = rd_word[req_q.addr[1:0]];
    rhalf = req_q.addr[1] ? rd_word[3:2] : rd_word[1:0];
    case (req_q.rctl)
      3'b001:  rdata_next = {{24{rbyte[7]}}, rbyte};
      3'b010:  rdata_next = {{16{rhalf[15]}}, rhalf};
      3'b011:  rdata_next = rd_word;
      3'b100:  rdata_next = {24'd0, rbyte};
      3'b101:  rdata_next = {16'd0, rhalf};
      default: rdata_next = 32'd0;
    endcase
  end

  // Counter loads WAIT_STATES and the op fires on the edge after it reaches 0,
  // giving rsp_valid exactly WAIT_STATES+1 cycles after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
`ifdef DATA_MEM_STATS_EN
      read_count  <= 32'd0;
      write_count <= 32'd0;
`endif
    end else begin
      case (state)
        S_IDLE:
          if (req_valid) begin
            req_q     <= '{req_addr, req_write_ctrl, req_read_ctrl, req_wdata};
            cnt       <= 4'(WAIT_STATES);
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end
        S_WAIT:
          if (cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_error <= acc_err;
            rsp_rdata <= acc_err ? 32'd0 : rdata_next;
            state     <= S_RESP;
`ifdef DATA_MEM_STATS_EN
            if (!acc_err && (req_q.rctl != 3'b000)) read_count  <= read_count + 32'd1;
            if (!acc_err && (req_q.wctl != 2'b00))  write_count <= write_count + 32'd1;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        S_RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
